// File: rtl/dpc_loop_pkg.sv
// Shared types and constants for the decade loop counter.
// Digits are 10-bit one-hot rings: bit p set means the digit shows p.
package dpc_loop_pkg;

  localparam int unsigned DIGIT_W = 10;
  localparam int unsigned CNT_W   = 4;

  localparam logic [DIGIT_W-1:0] ZERO = 10'b00_0000_0001;
  localparam logic [DIGIT_W-1:0] NINE = 10'b10_0000_0000;

  typedef enum logic [1:0] {
    INC  = 2'd0,
    DEC  = 2'd1,
    LOAD = 2'd2,
    CLR  = 2'd3
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Any field that is not exactly one-hot collapses to position 0.
  function automatic logic [DIGIT_W-1:0] sanitize(input logic [DIGIT_W-1:0] d);
    return $onehot(d) ? d : ZERO;
  endfunction

endpackage

// File: rtl/decade_digit.sv
// One decade digit: a 10-position one-hot ring that can step up/down,
// load a (sanitized) code or clear, and flags the 9 and 0 positions.
module decade_digit
  import dpc_loop_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic               clr,
  input  logic [DIGIT_W-1:0] load_value,
  output logic [DIGIT_W-1:0] value,
  output logic               at9,
  output logic               at0
);

  // Rotating the ring keeps the code one-hot by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= ZERO;
    end else if (clr) begin
      value <= ZERO;
    end else if (load) begin
      value <= sanitize(load_value);
    end else if (en) begin
      value <= up ? {value[DIGIT_W-2:0], value[DIGIT_W-1]}
                  : {value[0], value[DIGIT_W-1:1]};
    end
  end

  assign at9 = |(value & NINE);
  assign at0 = |(value & ZERO);

endmodule

// File: rtl/decade_loop_counter.sv
// Multi-digit one-hot decade counter with a fixed-latency request handshake
// and sticky wrap flags.
module decade_loop_counter
  import dpc_loop_pkg::*;
#(
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      request,
  input  logic [1:0]                op,
  input  logic [DIGITS*DIGIT_W-1:0] load_value,
  input  logic                      flag_clr,
  output logic                      ready,
  output logic [DIGITS*DIGIT_W-1:0] value,
  output logic                      zero,
  output logic                      overflow,
  output logic                      underflow
);

  state_e                    state;
  state_e                    next_state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_next;
  op_e                       op_q;
  logic [DIGITS*DIGIT_W-1:0] load_q;
  logic                      accept_c;
  logic                      commit_c;
  logic                      step_c;
  logic                      up_c;
  logic                      load_c;
  logic                      clr_c;
  logic                      run_c;
  logic                      wrap_up_c;
  logic                      wrap_dn_c;
  logic [DIGITS-1:0]         en;
  logic [DIGITS-1:0]         at9;
  logic [DIGITS-1:0]         at0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ready  <= 1'b1;
      op_q   <= INC;
      load_q <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      ready <= (next_state == IDLE);
      if (accept_c) begin
        op_q   <= op_e'(op);
        load_q <= load_value;
      end
    end
  end

  // Commit fires on the edge where the countdown reaches zero.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    commit_c   = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          accept_c   = 1'b1;
          cnt_next   = CNT_W'(STEP_CYCLES);
          next_state = BUSY;
        end
      end
      BUSY: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit_c   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign step_c = commit_c && ((op_q == INC) || (op_q == DEC));
  assign up_c   = (op_q == INC);
  assign load_c = commit_c && (op_q == LOAD);
  assign clr_c  = commit_c && (op_q == CLR);

  // Ripple carry/borrow: a digit moves only if every lower digit is at its wrap point.
  always_comb begin
    en    = '0;
    run_c = step_c;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      en[k] = run_c;
      run_c = run_c & (up_c ? at9[k] : at0[k]);
    end
  end

  assign wrap_up_c = step_c &  up_c & (&at9);
  assign wrap_dn_c = step_c & ~up_c & (&at0);

  // A wrap on the same edge as flag_clr leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrap_up_c)     overflow <= 1'b1;
      else if (flag_clr) overflow <= 1'b0;
      if (wrap_dn_c)     underflow <= 1'b1;
      else if (flag_clr) underflow <= 1'b0;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    decade_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .en         (en[k]),
      .up         (up_c),
      .load       (load_c),
      .clr        (clr_c),
      .load_value (load_q[k*DIGIT_W +: DIGIT_W]),
      .value      (value[k*DIGIT_W +: DIGIT_W]),
      .at9        (at9[k]),
      .at0        (at0[k])
    );
  end

  assign zero = &at0;

endmodule

// File: tb/tb_decade_loop_counter.sv
// Bench for decade_loop_counter: two instances (1- and 3-cycle latency) run in
// lockstep against an integer-valued reference model, plus directed scenarios.
module tb_decade_loop_counter;
  import dpc_loop_pkg::*;

  localparam int unsigned D    = 2;
  localparam int unsigned VW   = D * DIGIT_W;
  localparam int          MAXV = 99;

  logic          clk = 1'b0;
  logic          rst;
  logic          request;
  logic [1:0]    op;
  logic [VW-1:0] load_value;
  logic          flag_clr;
  logic [1:0]    ready;
  logic [1:0]    zero;
  logic [1:0]    ovf;
  logic [1:0]    unf;
  logic [VW-1:0] value [2];

  always #5 clk = ~clk;

  decade_loop_counter #(.DIGITS(D), .STEP_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst), .request(request), .op(op), .load_value(load_value),
    .flag_clr(flag_clr), .ready(ready[0]), .value(value[0]), .zero(zero[0]),
    .overflow(ovf[0]), .underflow(unf[0])
  );

  decade_loop_counter #(.DIGITS(D), .STEP_CYCLES(3)) dut_s3 (
    .clk(clk), .rst(rst), .request(request), .op(op), .load_value(load_value),
    .flag_clr(flag_clr), .ready(ready[1]), .value(value[1]), .zero(zero[1]),
    .overflow(ovf[1]), .underflow(unf[1])
  );

  // Reference model state: counter as a plain integer 0..99
  int            mv    [2];
  bit            mov   [2];
  bit            mun   [2];
  bit            mbusy [2];
  int            mdone [2];
  int            mop   [2];
  logic [VW-1:0] mld   [2];
  int            scyc  [2] = '{1, 3};
  int            cyc;
  int            checks;
  int            errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] enc(input int v);
    logic [VW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < D; k++) begin
      r[k*DIGIT_W + (t % 10)] = 1'b1;
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int dec_load(input logic [VW-1:0] ld);
    logic [DIGIT_W-1:0] f;
    int v, p, pos;
    v = 0;
    p = 1;
    for (int k = 0; k < D; k++) begin
      f   = ld[k*DIGIT_W +: DIGIT_W];
      pos = 0;
      if ($countones(f) == 1)
        for (int b = 0; b < DIGIT_W; b++) if (f[b]) pos = b;
      v += pos * p;
      p *= 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mov[i] = 0; mun[i] = 0; mbusy[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit wo, wu;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      wo = 0;
      wu = 0;
      if (mbusy[i]) begin
        if (cyc == mdone[i]) begin
          case (mop[i])
            0: if (mv[i] == MAXV) begin mv[i] = 0; wo = 1; end else mv[i]++;
            1: if (mv[i] == 0) begin mv[i] = MAXV; wu = 1; end else mv[i]--;
            2: mv[i] = dec_load(mld[i]);
            default: mv[i] = 0;
          endcase
          mbusy[i] = 0;
        end
      end else if (request) begin
        mbusy[i] = 1;
        mdone[i] = cyc + scyc[i];
        mop[i]   = int'(op);
        mld[i]   = load_value;
      end
      if (wo) mov[i] = 1; else if (flag_clr) mov[i] = 0;
      if (wu) mun[i] = 1; else if (flag_clr) mun[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("model_value%0d", i), 64'(value[i]), 64'(enc(mv[i])));
      check($sformatf("model_ready%0d", i), 64'(ready[i]), 64'(!mbusy[i]));
      check($sformatf("model_zero%0d", i),  64'(zero[i]),  64'(mv[i] == 0));
      check($sformatf("model_ovf%0d", i),   64'(ovf[i]),   64'(mov[i]));
      check($sformatf("model_unf%0d", i),   64'(unf[i]),   64'(mun[i]));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    request  = 1'b0;
    flag_clr = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic pulse_op(input logic [1:0] o, input logic [VW-1:0] ld);
    op         = o;
    load_value = ld;
    request    = 1'b1;
    cycle();
    request    = 1'b0;
    idle(4);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    request  = 1'b0;
    flag_clr = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_value", 64'(value[i]), 64'h401);
      check("rst_ready", 64'(ready[i]), 64'd1);
      check("rst_zero",  64'(zero[i]),  64'd1);
      check("rst_ovf",   64'(ovf[i]),   64'd0);
      check("rst_unf",   64'(unf[i]),   64'd0);
    end
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [DIGIT_W-1:0] f;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    op         = 2'd0;
    load_value = '0;
    apply_reset();

    // INC sweep 00..99 -> 00 on the single-cycle instance
    op = 2'd0;
    for (int n = 1; n <= 100; n++) begin
      request = 1'b1;
      cycle();
      request = 1'b0;
      cycle();
      check("sweep_value", 64'(value[0]), 64'(enc(n % 100)));
      check("sweep_ovf",   64'(ovf[0]),   64'(n == 100));
    end
    check("sweep_zero_end", 64'(zero[0]), 64'd1);
    idle(4);

    // DEC from 00 wraps to 99 and sets underflow; flag_clr clears it
    apply_reset();
    pulse_op(2'd1, '0);
    check("dec_wrap_value", 64'(value[0]), 64'h80200);
    check("dec_wrap_unf",   64'(unf[0]),   64'd1);
    check("dec_wrap_ovf",   64'(ovf[0]),   64'd0);
    flag_clr = 1'b1;
    cycle();
    flag_clr = 1'b0;
    check("flag_clr_unf", 64'(unf[0]), 64'd0);

    // 3-cycle latency; request during busy ignored
    apply_reset();
    op      = 2'd0;
    request = 1'b1;
    cycle();
    check("lat_busy1", 64'(ready[1]), 64'd0);
    op = 2'd1;
    cycle();
    check("lat_busy2", 64'(ready[1]), 64'd0);
    request = 1'b0;
    cycle();
    check("lat_busy3",  64'(ready[1]), 64'd0);
    check("lat_hold",   64'(value[1]), 64'h401);
    cycle();
    check("lat_ready",  64'(ready[1]), 64'd1);
    check("lat_value",  64'(value[1]), 64'h402);
    idle(4);

    // LOAD with an illegal digit, flags untouched, then CLR
    apply_reset();
    pulse_op(2'd1, '0);
    pulse_op(2'd2, {10'h003, 10'h080});
    check("load_value", 64'(value[0]), 64'h480);
    check("load_unf",   64'(unf[0]),   64'd1);
    pulse_op(2'd3, '0);
    check("clr_zero0", 64'(zero[0]), 64'd1);
    check("clr_zero1", 64'(zero[1]), 64'd1);
    check("clr_unf",   64'(unf[0]),  64'd1);

    // Overflow set beats flag_clr on the same edge; reset aborts a busy op
    apply_reset();
    pulse_op(2'd2, {NINE, NINE});
    op      = 2'd0;
    request = 1'b1;
    cycle();
    request  = 1'b0;
    flag_clr = 1'b1;
    cycle();
    flag_clr = 1'b0;
    check("ovf_vs_clr",  64'(ovf[0]),   64'd1);
    check("ovf_value",   64'(value[0]), 64'h401);
    check("busy_pre_rst", 64'(ready[1]), 64'd0);
    rst = 1'b1;
    model_reset();
    #1;
    check("abort_value", 64'(value[1]), 64'h401);
    check("abort_ready", 64'(ready[1]), 64'd1);
    check("abort_ovf",   64'(ovf[0]),   64'd0);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    idle(5);
    check("abort_no_late", 64'(value[1]), 64'h401);

    // Randomized traffic against the model
    for (int it = 0; it < 2500; it++) begin
      rst      = ($urandom % 150) == 0;
      request  = ($urandom % 3) != 0;
      op       = 2'($urandom % 4);
      flag_clr = ($urandom % 8) == 0;
      if (($urandom % 8) == 0) begin
        load_value = ($urandom % 2) ? {NINE, NINE} : {ZERO, ZERO};
      end else begin
        for (int k = 0; k < D; k++) begin
          if (($urandom % 4) == 0) f = 10'($urandom);
          else                     f = 10'd1 << ($urandom % 10);
          load_value[k*DIGIT_W +: DIGIT_W] = f;
        end
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
